// File: rtl/alu_spi_master.sv
// SPI mode-0 master: ships {opcode, a, b} MSB first, waits one SCLK period, then reads the result back.
// Define ALU_SPI_OPCHK_EN to reject unsupported opcodes with a one-cycle err pulse and no bus activity.
module alu_spi_master #(
  parameter int BIT_LENGTH    = 8,
  parameter int INSTR_LENGTH  = 20,
  parameter int OPCODE_LENGTH = 4,
  parameter int CLK_DIV       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BIT_LENGTH-1:0]    a,
  input  logic [BIT_LENGTH-1:0]    b,
  input  logic [OPCODE_LENGTH-1:0] opcode,
  input  logic                     start,
  output logic                     ready,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  input  logic                     miso,
  output logic [INSTR_LENGTH-1:0]  result,
  output logic                     res_valid,
  output logic                     err
);
  localparam int CNT_W = (2*CLK_DIV > 1) ? $clog2(2*CLK_DIV) : 1;
  localparam int BIT_W = (INSTR_LENGTH > 1) ? $clog2(INSTR_LENGTH) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV-1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(2*CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(INSTR_LENGTH-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_TX    = 3'd2,
    S_TURN  = 3'd3,
    S_RX    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [BIT_W-1:0]        r_bit;
  logic [INSTR_LENGTH-1:0] r_tx_sh, r_rx_sh, r_result;
  logic                    r_ready, r_sclk, r_cs_n, r_mosi, r_res_valid, r_err;
  logic                    w_sclk_nxt, w_cs_n_nxt, w_mosi_nxt, w_res_valid_nxt, w_err_nxt;
  logic                    w_half_end, w_per_end, w_last_bit, w_op_ok, w_accept, w_sample;
  logic [INSTR_LENGTH-1:0] w_frame;

`ifdef ALU_SPI_OPCHK_EN
  function automatic logic f_op_legal(input logic [OPCODE_LENGTH-1:0] op);
    return (32'(op) <= 32'd8);
  endfunction
  assign w_op_ok = f_op_legal(opcode);
`else
  assign w_op_ok = 1'b1;
`endif

  assign w_frame    = {opcode, a, b};
  assign w_half_end = (r_cnt == HALF_LAST);
  assign w_per_end  = (r_cnt == PER_LAST);
  assign w_last_bit = (r_bit == BIT_LAST);
  assign w_accept   = start && r_ready && w_op_ok;
  // miso is taken on the clk edge that raises sclk, i.e. the slave's sampling edge
  assign w_sample   = ((r_state == S_TURN) && w_per_end) ||
                      ((r_state == S_RX) && w_per_end && !w_last_bit);

  // state register, phase/bit counters and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_bit    <= {BIT_W{1'b0}};
      r_tx_sh  <= {INSTR_LENGTH{1'b0}};
      r_rx_sh  <= {INSTR_LENGTH{1'b0}};
      r_result <= {INSTR_LENGTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) || (r_state != w_state_nxt) || w_per_end) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (((r_state == S_TX) || (r_state == S_RX)) && w_per_end) begin
        r_bit <= w_last_bit ? {BIT_W{1'b0}} : (r_bit + BIT_W'(1));
      end else if ((r_state == S_TX) || (r_state == S_RX)) begin
        r_bit <= r_bit;
      end else begin
        r_bit <= {BIT_W{1'b0}};
      end
      if (w_accept) begin
        r_tx_sh <= w_frame;
      end else if ((r_state == S_TX) && w_half_end) begin
        r_tx_sh <= {r_tx_sh[INSTR_LENGTH-2:0], 1'b0};
      end else begin
        r_tx_sh <= r_tx_sh;
      end
      if (w_accept) begin
        r_rx_sh <= {INSTR_LENGTH{1'b0}};
      end else if (w_sample) begin
        r_rx_sh <= {r_rx_sh[INSTR_LENGTH-2:0], miso};
      end else begin
        r_rx_sh <= r_rx_sh;
      end
      r_result <= (r_state == S_DONE) ? r_rx_sh : r_result;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_SETUP : S_IDLE;
      S_SETUP: w_state_nxt = w_half_end ? S_TX : S_SETUP;
      S_TX:    w_state_nxt = (w_per_end && w_last_bit) ? S_TURN : S_TX;
      S_TURN:  w_state_nxt = w_per_end ? S_RX : S_TURN;
      S_RX:    w_state_nxt = (w_per_end && w_last_bit) ? S_DONE : S_RX;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // next values for the registered bus/status outputs; each period is high half then low half
  always_comb begin
    w_sclk_nxt      = 1'b0;
    w_cs_n_nxt      = 1'b1;
    w_mosi_nxt      = 1'b0;
    w_res_valid_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err_nxt  = start && r_ready && !w_op_ok;
        w_cs_n_nxt = !w_accept;
        w_mosi_nxt = w_accept ? w_frame[INSTR_LENGTH-1] : 1'b0;
      end
      S_SETUP: begin
        w_cs_n_nxt = 1'b0;
        w_mosi_nxt = r_mosi;
        w_sclk_nxt = w_half_end;
      end
      S_TX: begin
        w_cs_n_nxt = 1'b0;
        if (w_half_end) begin
          w_sclk_nxt = 1'b0;
          w_mosi_nxt = r_tx_sh[INSTR_LENGTH-2];
        end else if (w_per_end) begin
          w_sclk_nxt = !w_last_bit;
          w_mosi_nxt = r_mosi;
        end else begin
          w_sclk_nxt = r_sclk;
          w_mosi_nxt = r_mosi;
        end
      end
      S_TURN: begin
        w_cs_n_nxt = 1'b0;
        w_sclk_nxt = w_per_end;
      end
      S_RX: begin
        if (w_half_end) begin
          w_sclk_nxt = 1'b0;
          w_cs_n_nxt = 1'b0;
        end else if (w_per_end) begin
          w_sclk_nxt = !w_last_bit;
          w_cs_n_nxt = w_last_bit;
        end else begin
          w_sclk_nxt = r_sclk;
          w_cs_n_nxt = 1'b0;
        end
      end
      S_DONE:  w_res_valid_nxt = 1'b1;
      default: w_cs_n_nxt = 1'b1;
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b1;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ready     <= (w_state_nxt == S_IDLE);
      r_sclk      <= w_sclk_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign ready     = r_ready;
  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;
  assign result    = r_result;
  assign res_valid = r_res_valid;
  assign err       = r_err;
endmodule
